gemm_tile_sequencer: RTL
========================

# gemm_tile_sequencer

Queued GEMM command sequencer for the tensor processing cluster. It accepts whole-matrix GEMM descriptors (M×K · K×N, dimensions multiples of ARRAY_SIZE) into a small command queue, then walks each one into ARRAY_SIZE×ARRAY_SIZE tile operations for the systolic array controller. It tracks tile retirement, so back-to-back GEMMs in one program execute in order, and a later GEMM never starts before the previous one's results are written. It sits between the instruction decoder's tensor-op path and the systolic array controller.

## Interface
Parameters:
- ARRAY_SIZE, 4, systolic dimension; power of two
- DIM_W, 16, width of M/N/K fields
- ADDR_W, 20, SRAM row address width
- QUEUE_DEPTH, 4, command FIFO entries; power of two
- MAX_OUT, 4, maximum issued-but-unretired tiles
- ID_W, 4, command tag width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid / cmd_ready  in / out  1  descriptor handshake
- cmd_dst, cmd_act, cmd_wgt  in  ADDR_W  base rows of C, A, B^T
- cmd_m, cmd_n, cmd_k  in  DIM_W  matrix dimensions
- cmd_id  in  ID_W  tag
- tile_valid / tile_ready  out / in  1  tile-op handshake
- tile_dst, tile_act, tile_wgt  out  ADDR_W  tile row addresses
- tile_first_k, tile_last_k  out  1  clear accumulator / write back C tile
- tile_id  out  ID_W  owning command tag
- tile_done_in  in  1  one tile retired by array controller
- cmd_done  out  1  single-cycle completion pulse
- cmd_done_id  out  ID_W  tag of completed command
- cmd_err  out  1  qualifies cmd_done: command rejected
- busy  out  1  queue non-empty, FSM not IDLE, or outstanding ≠ 0
- err_underflow  out  1  sticky: tile_done_in while outstanding = 0

## Operation
- Queue: cmd_ready = !full. Push on cmd_valid&&cmd_ready; push and pop in the same cycle is allowed when full.
- FSM: IDLE → LOAD (pop head) → ISSUE → DRAIN → IDLE, or LOAD → DONE_ERR → IDLE.
- LOAD: MT=M/AS, NT=N/AS, KT=K/AS via shifts. If any dimension is zero or not a multiple of AS → DONE_ERR. DONE_ERR pulses cmd_done with cmd_err=1, issues no tiles, consumes one cycle.
- ISSUE order: m_t outer, n_t middle, k_t inner. Addresses are tile-major, in rows:
  - act = act_base + (m_t·KT + k_t)·AS
  - wgt = wgt_base + (k_t·NT + n_t)·AS
  - dst = dst_base + (m_t·NT + n_t)·AS
- Addresses are produced with incremental adders, with no multipliers. They wrap modulo 2^ADDR_W.
- tile_first_k = (k_t==0). tile_last_k = (k_t==KT-1).
- tile_valid is suppressed while outstanding == MAX_OUT.
- outstanding counter: +1 on tile handshake, −1 on tile_done_in. Both in the same cycle leave it unchanged. tile_done_in at 0 sets err_underflow and does not change the count.
- After the last tile handshake → DRAIN. Leave when outstanding reaches 0: pulse cmd_done (cmd_err=0, cmd_done_id = tag), then return to IDLE.

## Timing
- Reset values: cmd_ready=0 during rst and 1 the cycle after; all other outputs 0; queue empty; FSM IDLE; counters 0.
- Reset mid-operation flushes the queue and the in-flight command, with no cmd_done.
- Latency: with an idle block and empty queue, a push at cycle t gives tile_valid at t+2 (LOAD at t+1).
- Tile payload is stable while tile_valid && !tile_ready. Once raised, tile_valid is not dropped before the handshake.
- Peak rate is one tile per cycle with tile_ready held high.
- cmd_done asserts the cycle after the tile_done_in that brings outstanding to 0.
- The next command's LOAD comes the cycle after cmd_done, giving a 2-cycle gap per command.

## Configuration
- GEMM_SEQ_PERF_EN defined: adds 32-bit saturating outputs perf_tiles (tile handshakes), perf_stall (tile_valid && !tile_ready, or blocked by MAX_OUT) and perf_busy (busy cycles). All three clear on rst.
- GEMM_SEQ_PERF_EN undefined: these ports and registers are absent, and function is otherwise identical.

## Structure
- Shared package gemm_seq_pkg holds:
  - the FSM state enum
  - the descriptor struct (dst/act/wgt/m/n/k/id)
  - the tile-op struct
- Sub-module: gemm_cmd_fifo, a parametrised synchronous FIFO of descriptors with full/empty flags.

## Test plan
- Two queued 4×4 GEMMs (dst 0x20/act 0x10/wgt 0x00, then dst 0x60/act 0x50/wgt 0x40), each tile retired 3 cycles after issue:
  - two tiles, each with first_k=last_k=1
  - cmd_done id0 completes before the id1 tile issues.
- M=N=K=8, tile_ready=1, retire on issue:
  - 8 tiles in order (m,n,k) = 000, 001, 010, 011, 100, …
  - tile 0x0001 (m=0, n=0, k=1) has act=base+4, wgt=base+8, dst=base+0.
- Random tile_ready backpressure on 8×8×8: payload holds while stalled, and exactly 8 handshakes occur.
- No retirements with MAX_OUT=4: tile_valid stays low after 4 issues until a tile_done_in arrives.
- Push QUEUE_DEPTH+1 descriptors while stalled: cmd_ready falls after 4 pushes.
- cmd_k=6: cmd_done with cmd_err=1 two cycles after the push, and zero tiles issued.
- rst asserted mid-ISSUE: next cycle all outputs 0 and the queue empty. No cmd_done for the flushed command.
- tile_done_in with outstanding = 0: err_underflow sets and stays set until rst.

Source files
------------

// File: rtl/gemm_seq_pkg.sv
// Shared types for the GEMM tile sequencer: FSM states,
// queued descriptor and per-tile operation bundles.
package gemm_seq_pkg;

    localparam int SEQ_ADDR_W = 20;
    localparam int SEQ_DIM_W  = 16;
    localparam int SEQ_ID_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE_ERR
    } seq_state_e;

    typedef struct packed {
        logic [SEQ_ADDR_W-1:0] dst;
        logic [SEQ_ADDR_W-1:0] act;
        logic [SEQ_ADDR_W-1:0] wgt;
        logic [SEQ_DIM_W-1:0]  m;
        logic [SEQ_DIM_W-1:0]  n;
        logic [SEQ_DIM_W-1:0]  k;
        logic [SEQ_ID_W-1:0]   id;
    } gemm_desc_t;

    typedef struct packed {
        logic [SEQ_ADDR_W-1:0] dst;
        logic [SEQ_ADDR_W-1:0] act;
        logic [SEQ_ADDR_W-1:0] wgt;
        logic                  first_k;
        logic                  last_k;
        logic [SEQ_ID_W-1:0]   id;
    } tile_op_t;

endpackage

// File: rtl/gemm_cmd_fifo.sv
// Synchronous descriptor FIFO with full/empty flags.
// A push is accepted while full when a pop happens in the same cycle.
module gemm_cmd_fifo
    import gemm_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  gemm_desc_t wr_data,
    input  logic       pop,
    output gemm_desc_t rd_data,
    output logic       full,
    output logic       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    gemm_desc_t      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Walks queued GEMM descriptors into ARRAY_SIZE^2 tile ops.
// GEMM_SEQ_PERF_EN adds saturating perf counters.
module gemm_tile_sequencer
    import gemm_seq_pkg::*;
#(
    parameter int ARRAY_SIZE  = 4,
    parameter int DIM_W       = 16,
    parameter int ADDR_W      = 20,
    parameter int QUEUE_DEPTH = 4,
    parameter int MAX_OUT     = 4,
    parameter int ID_W        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_act,
    input  logic [ADDR_W-1:0] cmd_wgt,
    input  logic [DIM_W-1:0]  cmd_m,
    input  logic [DIM_W-1:0]  cmd_n,
    input  logic [DIM_W-1:0]  cmd_k,
    input  logic [ID_W-1:0]   cmd_id,
    output logic              tile_valid,
    input  logic              tile_ready,
    output logic [ADDR_W-1:0] tile_dst,
    output logic [ADDR_W-1:0] tile_act,
    output logic [ADDR_W-1:0] tile_wgt,
    output logic              tile_first_k,
    output logic              tile_last_k,
    output logic [ID_W-1:0]   tile_id,
    input  logic              tile_done_in,
    output logic              cmd_done,
    output logic [ID_W-1:0]   cmd_done_id,
    output logic              cmd_err,
    output logic              busy,
    output logic              err_underflow
`ifdef GEMM_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_tiles,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_busy
`endif
);

    localparam int LOG_AS = $clog2(ARRAY_SIZE);
    localparam int OW     = $clog2(MAX_OUT + 1);
    localparam logic [ADDR_W-1:0] AS_A  = ADDR_W'(ARRAY_SIZE);
    localparam logic [OW-1:0]     MAX_O = OW'(MAX_OUT);

    seq_state_e        state, state_nx;
    gemm_desc_t        push_desc, head;
    tile_op_t          op;
    logic              fifo_full, fifo_empty;
    logic              push, pop, pending, fire;
    logic              k_end, n_end, m_end, load_bad;
    logic [DIM_W-1:0]  m_t, n_t, k_t;
    logic [DIM_W-1:0]  mt_last, nt_last, kt_last;
    logic [ADDR_W-1:0] act_a, act_row;
    logic [ADDR_W-1:0] wgt_a, wgt_col, wgt_base, wgt_kstride;
    logic [ADDR_W-1:0] dst_a;
    logic [ID_W-1:0]   cur_id;
    logic [OW-1:0]     outstanding;
    logic              ret_ok;

    assign push_desc.dst = cmd_dst;
    assign push_desc.act = cmd_act;
    assign push_desc.wgt = cmd_wgt;
    assign push_desc.m   = cmd_m;
    assign push_desc.n   = cmd_n;
    assign push_desc.k   = cmd_k;
    assign push_desc.id  = cmd_id;

    gemm_cmd_fifo #(
        .DEPTH   (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (push_desc),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign cmd_ready  = !fifo_full && !rst;
    assign push       = cmd_valid && cmd_ready;
    assign pending    = !fifo_empty || push;
    assign pop        = (state == ST_LOAD);
    assign tile_valid = (state == ST_ISSUE) && (outstanding != MAX_O);
    assign fire       = tile_valid && tile_ready;
    assign k_end      = (k_t == kt_last);
    assign n_end      = (n_t == nt_last);
    assign m_end      = (m_t == mt_last);
    assign ret_ok     = tile_done_in && (outstanding != '0);
    assign busy       = !fifo_empty || (state != ST_IDLE)
                        || (outstanding != '0);

    assign load_bad = (head.m == '0) || (head.n == '0)
                   || (head.k == '0)
                   || (|head.m[LOG_AS-1:0])
                   || (|head.n[LOG_AS-1:0])
                   || (|head.k[LOG_AS-1:0]);

    assign op.dst     = dst_a;
    assign op.act     = act_a;
    assign op.wgt     = wgt_a;
    assign op.first_k = (state == ST_ISSUE) && (k_t == '0);
    assign op.last_k  = (state == ST_ISSUE) && k_end;
    assign op.id      = cur_id;

    assign tile_dst     = op.dst;
    assign tile_act     = op.act;
    assign tile_wgt     = op.wgt;
    assign tile_first_k = op.first_k;
    assign tile_last_k  = op.last_k;
    assign tile_id      = op.id;
    assign cmd_done_id  = cmd_done ? cur_id : '0;

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // next state and completion pulses
    always_comb begin
        state_nx = state;
        cmd_done = 1'b0;
        cmd_err  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pending)
                    state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                state_nx = load_bad ? ST_DONE_ERR : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (fire && k_end && n_end && m_end)
                    state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (outstanding == '0) begin
                    cmd_done = 1'b1;
                    state_nx = pending ? ST_LOAD : ST_IDLE;
                end
            end
            ST_DONE_ERR: begin
                cmd_done = 1'b1;
                cmd_err  = 1'b1;
                state_nx = pending ? ST_LOAD : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // tile counters and incremental address walk
    always_ff @(posedge clk) begin
        if (rst) begin
            m_t         <= '0;
            n_t         <= '0;
            k_t         <= '0;
            mt_last     <= '0;
            nt_last     <= '0;
            kt_last     <= '0;
            act_a       <= '0;
            act_row     <= '0;
            wgt_a       <= '0;
            wgt_col     <= '0;
            wgt_base    <= '0;
            wgt_kstride <= '0;
            dst_a       <= '0;
            cur_id      <= '0;
        end else if (state == ST_LOAD) begin
            m_t         <= '0;
            n_t         <= '0;
            k_t         <= '0;
            mt_last     <= (head.m >> LOG_AS) - 1'b1;
            nt_last     <= (head.n >> LOG_AS) - 1'b1;
            kt_last     <= (head.k >> LOG_AS) - 1'b1;
            act_a       <= head.act;
            act_row     <= head.act;
            wgt_a       <= head.wgt;
            wgt_col     <= head.wgt;
            wgt_base    <= head.wgt;
            wgt_kstride <= ADDR_W'(head.n);
            dst_a       <= head.dst;
            cur_id      <= head.id;
        end else if (fire) begin
            if (!k_end) begin
                k_t   <= k_t + 1'b1;
                act_a <= act_a + AS_A;
                wgt_a <= wgt_a + wgt_kstride;
            end else begin
                k_t   <= '0;
                dst_a <= dst_a + AS_A;
                if (!n_end) begin
                    n_t     <= n_t + 1'b1;
                    act_a   <= act_row;
                    wgt_col <= wgt_col + AS_A;
                    wgt_a   <= wgt_col + AS_A;
                end else begin
                    n_t     <= '0;
                    m_t     <= m_t + 1'b1;
                    act_a   <= act_a + AS_A;
                    act_row <= act_a + AS_A;
                    wgt_col <= wgt_base;
                    wgt_a   <= wgt_base;
                end
            end
        end
    end

    // outstanding tile count and sticky underflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding   <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (tile_done_in && outstanding == '0)
                err_underflow <= 1'b1;
            if (fire && !ret_ok)
                outstanding <= outstanding + 1'b1;
            else if (ret_ok && !fire)
                outstanding <= outstanding - 1'b1;
        end
    end

`ifdef GEMM_SEQ_PERF_EN
    // saturating handshake, stall and busy counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_tiles <= '0;
            perf_stall <= '0;
            perf_busy  <= '0;
        end else begin
            if (fire && perf_tiles != '1)
                perf_tiles <= perf_tiles + 1'b1;
            if (state == ST_ISSUE && !fire && perf_stall != '1)
                perf_stall <= perf_stall + 1'b1;
            if (busy && perf_busy != '1)
                perf_busy <= perf_busy + 1'b1;
        end
    end
`else
`endif

endmodule
